// File: rtl/ps2_key_queue.sv
// rtl/ps2_key_queue.sv - PS/2 make-code filter feeding a key FIFO
// Optional line-edit mode (Enter commits, Backspace erases) selected by KEY_QUEUE_LINE_EDIT_EN.
module ps2_key_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ps2_received_data,
    input  logic              ps2_received_data_strb,
    output logic [7:0]        key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [ADDR_W:0]   key_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);

    state_t state;
    state_t state_next;
    logic   make_code;

    logic [7:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so a full queue is distinguishable from an empty one.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] cm_ptr;
    logic [ADDR_W:0] rd_next;

    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic bksp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        make_code  = 1'b0;
        if (ps2_received_data_strb) begin
            case (state)
                IDLE: begin
                    case (ps2_received_data)
                        8'hF0: state_next = BREAK;
                        8'hE0: state_next = EXT;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_next = IDLE;
                        default: make_code = 1'b1;
                    endcase
                end
                BREAK: state_next = IDLE;
                EXT: begin
                    if (ps2_received_data == 8'hF0) begin
                        state_next = EXT_BREAK;
                    end else begin
                        state_next = IDLE;
                    end
                end
                EXT_BREAK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign key_count = wr_ptr - rd_ptr;
    assign full      = (key_count == DEPTH_P);
    assign key_valid = (rd_ptr != cm_ptr);
    assign pop       = key_valid & key_ready;
    assign push      = push_req & (~full | pop);
    assign rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;

`ifdef KEY_QUEUE_LINE_EDIT_EN
    logic is_enter;
    logic is_bksp;

    assign is_enter = make_code && (ps2_received_data == 8'h5A);
    assign is_bksp  = make_code && (ps2_received_data == 8'h66);
    assign push_req = make_code && !is_enter && !is_bksp;
    // Backspace may only erase keys not yet released by Enter.
    assign bksp     = is_bksp && (wr_ptr != cm_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_ptr <= '0;
        end else if (is_enter) begin
            cm_ptr <= wr_ptr;
        end
    end
`else
    assign push_req = make_code;
    assign bksp     = 1'b0;
    assign cm_ptr   = wr_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (bksp) begin
                wr_ptr <= wr_ptr - 1'b1;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= ps2_received_data;
        end
    end

    // Head register: take the incoming byte when it lands at the next head slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_data <= 8'h00;
        end else if (push && (wr_ptr == rd_next)) begin
            key_data <= ps2_received_data;
        end else if (pop) begin
            key_data <= mem[rd_next[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_ps2_key_queue.sv
// tb/tb_ps2_key_queue.sv - directed self-checking bench for ps2_key_queue
module tb_ps2_key_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ps2_received_data = 8'h00;
    logic       ps2_received_data_strb = 1'b0;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [4:0] key_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_key_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ps2_received_data      (ps2_received_data),
        .ps2_received_data_strb (ps2_received_data_strb),
        .key_data               (key_data),
        .key_valid              (key_valid),
        .key_ready              (key_ready),
        .key_count              (key_count),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        key_ready = 1'b0;
        ps2_received_data_strb = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_received_data = b;
        ps2_received_data_strb = 1'b1;
        @(negedge clk);
        ps2_received_data_strb = 1'b0;
    endtask

    task automatic test_reset();
        send_byte(8'h1C);
        do_reset();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", key_valid); end
        checks++; if (key_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", key_count); end
        checks++; if (key_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", key_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_make_only();
        logic [7:0] exp [3];
        exp[0] = 8'h1C; exp[1] = 8'h29; exp[2] = 8'h32;
        do_reset();
        send_byte(8'h1C);
        checks++; if (key_valid !== 1'b1 || key_data !== 8'h1C) begin errors++; $display("FAIL latency got v=%0b d=%h want v=1 d=1c", key_valid, key_data); end
        send_byte(8'h29);
        send_byte(8'h32);
        checks++; if (key_count !== 5'd3) begin errors++; $display("FAIL make_count got %0d want 3", key_count); end
        checks++; if (key_data !== 8'h1C) begin errors++; $display("FAIL make_head got %h want 1c", key_data); end
        key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (key_valid !== 1'b1 || key_data !== exp[i]) begin errors++; $display("FAIL make_pop%0d got v=%0b d=%h want v=1 d=%h", i, key_valid, key_data, exp[i]); end
            @(negedge clk);
        end
        key_ready = 1'b0;
        checks++; if (key_valid !== 1'b0 || key_count !== 5'd0) begin errors++; $display("FAIL make_empty got v=%0b c=%0d want v=0 c=0", key_valid, key_count); end
    endtask

    task automatic test_break();
        do_reset();
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h21);
        checks++; if (key_count !== 5'd2) begin errors++; $display("FAIL break_count got %0d want 2", key_count); end
        key_ready = 1'b1;
        checks++; if (key_data !== 8'h1C) begin errors++; $display("FAIL break_pop0 got %h want 1c", key_data); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b1 || key_data !== 8'h21) begin errors++; $display("FAIL break_pop1 got v=%0b d=%h want v=1 d=21", key_valid, key_data); end
        @(negedge clk);
        key_ready = 1'b0;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL break_empty got %0b want 0", key_valid); end
    endtask

    task automatic test_ext_and_drop();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0);
        send_byte(8'hF0); send_byte(8'h75); send_byte(8'h32);
        checks++; if (key_count !== 5'd1 || key_data !== 8'h32) begin errors++; $display("FAIL ext_queue got c=%0d d=%h want c=1 d=32", key_count, key_data); end
        do_reset();
        send_byte(8'h00); send_byte(8'hAA); send_byte(8'hEE);
        send_byte(8'hFA); send_byte(8'hFE); send_byte(8'hFF);
        checks++; if (key_count !== 5'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL drop_codes got c=%0d v=%0b want c=0 v=0", key_count, key_valid); end
    endtask

    task automatic test_full();
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
        checks++; if (key_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", key_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %0b want 1", overflow); end
        checks++; if (key_data !== 8'h10) begin errors++; $display("FAIL full_head got %h want 10", key_data); end
        ps2_received_data = 8'h44;
        ps2_received_data_strb = 1'b1;
        key_ready = 1'b1;
        @(negedge clk);
        ps2_received_data_strb = 1'b0;
        key_ready = 1'b0;
        checks++; if (key_count !== 5'd16 || key_data !== 8'h11) begin errors++; $display("FAIL full_pushpop got c=%0d d=%h want c=16 d=11", key_count, key_data); end
        key_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            want = (i == 15) ? 8'h44 : 8'h11 + 8'(i);
            checks++; if (key_valid !== 1'b1 || key_data !== want) begin errors++; $display("FAIL full_drain%0d got v=%0b d=%h want v=1 d=%h", i, key_valid, key_data, want); end
            @(negedge clk);
        end
        key_ready = 1'b0;
        checks++; if (key_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL full_after got v=%0b ovf=%0b want v=0 ovf=1", key_valid, overflow); end
    endtask

    task automatic test_reset_mid_break();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        checks++; if (key_count !== 5'd1 || key_data !== 8'h1C || key_valid !== 1'b1) begin errors++; $display("FAIL midbreak_queue got c=%0d d=%h v=%0b want c=1 d=1c v=1", key_count, key_data, key_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midbreak_overflow got %0b want 0", overflow); end
    endtask

`ifdef KEY_QUEUE_LINE_EDIT_EN
    task automatic test_line_edit();
        do_reset();
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h66); send_byte(8'h21);
        checks++; if (key_valid !== 1'b0 || key_count !== 5'd2) begin errors++; $display("FAIL edit_pending got v=%0b c=%0d want v=0 c=2", key_valid, key_count); end
        send_byte(8'h5A);
        checks++; if (key_valid !== 1'b1 || key_count !== 5'd2) begin errors++; $display("FAIL edit_enter got v=%0b c=%0d want v=1 c=2", key_valid, key_count); end
        key_ready = 1'b1;
        checks++; if (key_data !== 8'h1C) begin errors++; $display("FAIL edit_pop0 got %h want 1c", key_data); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b1 || key_data !== 8'h21) begin errors++; $display("FAIL edit_pop1 got v=%0b d=%h want v=1 d=21", key_valid, key_data); end
        @(negedge clk);
        key_ready = 1'b0;
        send_byte(8'h66);
        checks++; if (key_valid !== 1'b0 || key_count !== 5'd0) begin errors++; $display("FAIL edit_bksp_empty got v=%0b c=%0d want v=0 c=0", key_valid, key_count); end
    endtask
`else
    task automatic test_plain_edit_codes();
        do_reset();
        send_byte(8'h5A); send_byte(8'h66);
        checks++; if (key_count !== 5'd2 || key_data !== 8'h5A) begin errors++; $display("FAIL plain_codes got c=%0d d=%h want c=2 d=5a", key_count, key_data); end
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_data !== 8'h66 || key_count !== 5'd1) begin errors++; $display("FAIL plain_pop got v=%0b d=%h c=%0d want v=1 d=66 c=1", key_valid, key_data, key_count); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_make_only();
        test_break();
        test_ext_and_drop();
        test_full();
        test_reset_mid_break();
`ifdef KEY_QUEUE_LINE_EDIT_EN
        test_line_edit();
`else
        test_plain_edit_codes();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_queue.md
PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 4).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_received_data  input  8  scan-code byte from the PS/2 controller.
REQ-006 SHALL have port ps2_received_data_strb  input  1  one-cycle byte-valid strobe from the PS/2 controller.
REQ-007 SHALL have port key_data  output  8  head-of-queue make code, going to the Morse encoder.
REQ-008 SHALL have port key_valid  output  1  key_data is poppable.
REQ-009 SHALL have port key_ready  input  1  consumer accepts key_data this cycle.
REQ-010 SHALL have port key_count  output  ADDR_W+1  number of stored entries, committed plus uncommitted.
REQ-011 SHALL have port overflow  output  1  sticky flag: a byte was dropped because the queue was full.

Function
REQ-012 SHALL run a filter FSM with states IDLE, BREAK, EXT and EXT_BREAK; it advances only on cycles where the strobe is high.
REQ-013 IDLE transitions SHALL be:
- 0xF0 -> BREAK.
- 0xE0 -> EXT.
- 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF are dropped and the FSM stays in IDLE.
- Any other byte is a make code, is pushed, and the FSM stays in IDLE.
REQ-014 BREAK transition SHALL be: any byte is dropped -> IDLE.
REQ-015 EXT transitions SHALL be: 0xF0 -> EXT_BREAK; any other byte is dropped -> IDLE.
REQ-016 EXT_BREAK transition SHALL be: any byte is dropped -> IDLE.
REQ-017 A push SHALL write the byte at the write pointer and increment the pointer modulo DEPTH.
REQ-018 A push when key_count==DEPTH SHALL drop the byte and set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-019 A pop SHALL occur when key_valid and key_ready are both 1; it advances the read pointer modulo DEPTH.
REQ-020 key_valid and key_ready low SHALL leave key_data and the read pointer unchanged.
REQ-021 key_data SHALL be registered and SHALL equal the entry at the read pointer whenever key_valid is 1.
REQ-022 key_valid SHALL be 1 if and only if committed entries exist, i.e. the read pointer is not equal to the commit pointer.
REQ-023 key_count SHALL follow these update rules:
- Push only: +1.
- Pop only: -1.
- Push and pop in the same cycle: unchanged.
- Never wraps below 0 or above DEPTH.
REQ-024 Latency SHALL be: a strobe in cycle N with an empty queue gives key_valid=1 with key_data=byte in cycle N+1, provided the byte is committed (see REQ-030..033).
REQ-025 overflow SHALL stay at 1 until reset.

Reset
REQ-026 On rst=1, asynchronously and regardless of state, the block SHALL force:
- filter FSM to IDLE;
- read, write and commit pointers to 0;
- key_count=0, key_valid=0, key_data=0x00, overflow=0.
REQ-027 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard the pending state; the first byte after release SHALL be decoded from IDLE.
REQ-028 Stored FIFO contents SHALL NOT be required to be cleared by reset.

Configuration
REQ-029 Macro KEY_QUEUE_LINE_EDIT_EN SHALL select line-edit mode.
REQ-030 With KEY_QUEUE_LINE_EDIT_EN defined, make code 0x5A (Enter) SHALL NOT be stored; it sets the commit pointer to the write pointer and releases the whole pending line.
REQ-031 With KEY_QUEUE_LINE_EDIT_EN defined, make code 0x66 (Backspace) SHALL NOT be stored; it decrements the write pointer and key_count when uncommitted entries exist, otherwise it is ignored.
REQ-032 With KEY_QUEUE_LINE_EDIT_EN defined, a Backspace in the same cycle as a pop SHALL be allowed; key_count then changes by -2.
REQ-033 Without KEY_QUEUE_LINE_EDIT_EN, 0x5A and 0x66 SHALL be stored like any make code, and the commit pointer SHALL track the write pointer every cycle, so every push is committed immediately.

Verification
REQ-034 Make-only: strobes 0x1C, 0x29, 0x32 with key_ready=0 -> key_count=3, key_data=0x1C; then key_ready=1 -> pops 0x1C, 0x29, 0x32 on consecutive cycles, then key_valid=0.
REQ-035 Break filtering: strobes 0x1C, 0xF0, 0x1C, 0x21 -> queue holds exactly 0x1C, 0x21.
REQ-036 Extended filtering: strobes 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0x32 -> queue holds 0x32 only.
REQ-037 Full and simultaneous access: DEPTH+1 pushes with key_ready=0 -> key_count=16, overflow=1; with key_count=16, a push and a pop in the same cycle -> key_count stays 16 and the new byte is stored last.
REQ-038 Reset mid-break: strobe 0xF0, pulse rst, strobe 0x1C -> 0x1C queued and overflow=0.
REQ-039 Line edit (macro defined): strobes 0x1C, 0x32, 0x66, 0x21 -> key_valid=0 and key_count=2; then 0x5A -> key_valid=1 and pops 0x1C, 0x21.
